// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, issues word reads to cache port 1, and
// buffers {PC, instruction} pairs for decode behind a valid/ready handshake.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FETCH_EN,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IF_RDEN,
    output logic [13:0] IF_ADDR,
    input  logic [31:0] IF_DIN,
    input  logic        IF_VALID,
    output logic        DEC_VALID,
    input  logic        DEC_READY,
    output logic [31:0] DEC_INSTR,
    output logic [31:0] DEC_PC
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_t;

    state_t        state, state_next;
    logic [31:0]   pc, pc_next;
    logic [13:0]   drop_addr, drop_addr_next;
    logic [31:0]   target;

    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_instr [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_after_push;

    logic          push, pop, pop_req, flush;

    assign target    = REDIRECT_PC & ~32'h3;
    assign DEC_VALID = (count != '0);
    assign DEC_PC    = fifo_pc[rd_ptr];
    assign DEC_INSTR = fifo_instr[rd_ptr];
    assign pop_req   = DEC_VALID && DEC_READY;
    // Occupancy if this cycle's capture is pushed; decides back-to-back issue.
    assign count_after_push = count + CW'(1) - CW'(pop_req);

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        drop_addr_next = drop_addr;
        push           = 1'b0;
        flush          = 1'b0;
        IF_RDEN        = 1'b0;
        IF_ADDR        = pc[15:2];

        case (state)
            S_IDLE: begin
                if (REDIRECT) begin
                    pc_next = target;
                    flush   = 1'b1;
                end else if (FETCH_EN && (count < DEPTH_C)) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                IF_RDEN = 1'b1;
                if (REDIRECT) begin
                    pc_next = target;
                    flush   = 1'b1;
                    if (IF_VALID) begin
                        state_next = S_IDLE;
                    end else begin
                        // Outstanding miss must complete on its original address.
                        state_next     = S_DROP;
                        drop_addr_next = pc[15:2];
                    end
                end else if (IF_VALID) begin
                    push    = 1'b1;
                    pc_next = pc + 32'd4;
                    if (!(FETCH_EN && (count_after_push < DEPTH_C))) begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                IF_RDEN = 1'b1;
                IF_ADDR = drop_addr;
                if (REDIRECT) begin
                    pc_next = target;
                end
                if (IF_VALID) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        pop = pop_req && !flush;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            pc        <= PC_INIT;
            drop_addr <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            drop_addr <= drop_addr_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= pc;
                fifo_instr[wr_ptr] <= IF_DIN;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a variable-latency instruction memory model.
module tb_ifetch_unit;

    logic        CLK;
    logic        RST;
    logic        FETCH_EN;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        IF_RDEN;
    logic [13:0] IF_ADDR;
    logic [31:0] IF_DIN;
    logic        IF_VALID;
    logic        DEC_VALID;
    logic        DEC_READY;
    logic [31:0] DEC_INSTR;
    logic [31:0] DEC_PC;

    int n_total = 0;
    int n_pass  = 0;
    int lat     = 0;
    int wait_cnt;

    ifetch_unit #(
        .RESET_PC  (32'h0000_0100),
        .FIFO_DEPTH(2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FETCH_EN   (FETCH_EN),
        .REDIRECT   (REDIRECT),
        .REDIRECT_PC(REDIRECT_PC),
        .IF_RDEN    (IF_RDEN),
        .IF_ADDR    (IF_ADDR),
        .IF_DIN     (IF_DIN),
        .IF_VALID   (IF_VALID),
        .DEC_VALID  (DEC_VALID),
        .DEC_READY  (DEC_READY),
        .DEC_INSTR  (DEC_INSTR),
        .DEC_PC     (DEC_PC)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mem_word(input logic [13:0] a);
        return {2'b10, a, 2'b01, ~a};
    endfunction

    // Memory answers once the current address has been requested for lat cycles.
    always @(posedge CLK or posedge RST) begin
        if (RST) wait_cnt <= 0;
        else if (IF_RDEN && !IF_VALID) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign IF_VALID = IF_RDEN && (wait_cnt >= lat);
    assign IF_DIN   = mem_word(IF_ADDR);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        RST = 1'b1; FETCH_EN = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0; DEC_READY = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_rden", 32'(IF_RDEN), 32'd0);
        chk("rst_addr", 32'(IF_ADDR), 32'h40);
        chk("rst_dvalid", 32'(DEC_VALID), 32'd0);
        chk("rst_dpc", DEC_PC, 32'd0);
        chk("rst_dinstr", DEC_INSTR, 32'd0);

        // 1: streaming hits from RESET_PC
        RST = 1'b0; FETCH_EN = 1'b1; DEC_READY = 1'b1;
        @(negedge CLK);
        chk("t1_rden", 32'(IF_RDEN), 32'd1);
        chk("t1_addr0", 32'(IF_ADDR), 32'h40);
        chk("t1_dvalid0", 32'(DEC_VALID), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("t1_addr", 32'(IF_ADDR), 32'h41 + 32'(k));
            chk("t1_dvalid", 32'(DEC_VALID), 32'd1);
            chk("t1_dpc", DEC_PC, 32'h100 + 32'(4 * k));
            chk("t1_dinstr", DEC_INSTR, mem_word(14'(32'h40 + 32'(k))));
        end

        // 2: back-pressure fills the FIFO, then drains in order
        DEC_READY = 1'b0;
        @(negedge CLK);
        chk("t2_rden_full", 32'(IF_RDEN), 32'd0);
        chk("t2_head0", DEC_PC, 32'h110);
        @(negedge CLK);
        chk("t2_rden_hold", 32'(IF_RDEN), 32'd0);
        chk("t2_head_hold", DEC_PC, 32'h110);
        DEC_READY = 1'b1;
        @(negedge CLK);
        chk("t2_head1", DEC_PC, 32'h114);
        chk("t2_head1_v", 32'(DEC_VALID), 32'd1);
        chk("t2_rden_idle", 32'(IF_RDEN), 32'd0);
        @(negedge CLK);
        chk("t2_empty", 32'(DEC_VALID), 32'd0);
        chk("t2_resume_rden", 32'(IF_RDEN), 32'd1);
        chk("t2_resume_addr", 32'(IF_ADDR), 32'h46);
        @(negedge CLK);
        chk("t2_next_pc", DEC_PC, 32'h118);
        chk("t2_next_addr", 32'(IF_ADDR), 32'h47);

        // 3: redirect during a miss; stale request completes and is dropped
        lat = 3; REDIRECT = 1'b1; REDIRECT_PC = 32'h2000;
        @(negedge CLK);
        REDIRECT = 1'b0;
        chk("t3_flush", 32'(DEC_VALID), 32'd0);
        chk("t3_drop_rden", 32'(IF_RDEN), 32'd1);
        chk("t3_drop_addr", 32'(IF_ADDR), 32'h47);
        repeat (2) @(negedge CLK);
        chk("t3_drop_hold", 32'(IF_ADDR), 32'h47);
        chk("t3_drop_dv", 32'(DEC_VALID), 32'd0);
        @(negedge CLK);
        chk("t3_idle_rden", 32'(IF_RDEN), 32'd0);
        chk("t3_idle_addr", 32'(IF_ADDR), 32'h800);
        chk("t3_no_stale", 32'(DEC_VALID), 32'd0);
        @(negedge CLK);
        chk("t3_new_addr", 32'(IF_ADDR), 32'h800);
        chk("t3_new_rden", 32'(IF_RDEN), 32'd1);
        repeat (4) @(negedge CLK);
        chk("t3_dv", 32'(DEC_VALID), 32'd1);
        chk("t3_dpc", DEC_PC, 32'h2000);
        chk("t3_dinstr", DEC_INSTR, mem_word(14'h800));

        // 4: redirect in the same cycle as the memory response
        repeat (3) @(negedge CLK);
        chk("t4_addr", 32'(IF_ADDR), 32'h801);
        chk("t4_popped", 32'(DEC_VALID), 32'd0);
        REDIRECT = 1'b1; REDIRECT_PC = 32'h40;
        @(negedge CLK);
        REDIRECT = 1'b0; lat = 0;
        chk("t4_dv_none", 32'(DEC_VALID), 32'd0);
        chk("t4_rden", 32'(IF_RDEN), 32'd0);
        chk("t4_addr_tgt", 32'(IF_ADDR), 32'h10);
        @(negedge CLK);
        chk("t4_dv_none2", 32'(DEC_VALID), 32'd0);
        @(negedge CLK);
        chk("t4_dpc", DEC_PC, 32'h40);
        chk("t4_dinstr", DEC_INSTR, mem_word(14'h10));

        // 5: asynchronous reset mid-miss
        lat = 3; DEC_READY = 1'b0;
        @(negedge CLK);
        chk("t5_pre_rden", 32'(IF_RDEN), 32'd1);
        chk("t5_pre_dv", 32'(DEC_VALID), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("t5_async_rden", 32'(IF_RDEN), 32'd0);
        chk("t5_async_dv", 32'(DEC_VALID), 32'd0);
        chk("t5_async_addr", 32'(IF_ADDR), 32'h40);
        @(negedge CLK);
        RST = 1'b0; lat = 0; DEC_READY = 1'b1;
        @(negedge CLK);
        chk("t5_restart_addr", 32'(IF_ADDR), 32'h40);
        chk("t5_restart_dv", 32'(DEC_VALID), 32'd0);
        @(negedge CLK);
        chk("t5_restart_dpc", DEC_PC, 32'h100);

        // 6: PC wrap through the 14-bit word address
        REDIRECT = 1'b1; REDIRECT_PC = 32'h0000_FFFF;
        @(negedge CLK);
        REDIRECT = 1'b0;
        chk("t6_idle_addr", 32'(IF_ADDR), 32'h3FFF);
        @(negedge CLK);
        chk("t6_req_addr", 32'(IF_ADDR), 32'h3FFF);
        @(negedge CLK);
        chk("t6_wrap_addr", 32'(IF_ADDR), 32'h0000);
        chk("t6_dpc0", DEC_PC, 32'h0000_FFFC);
        chk("t6_dinstr0", DEC_INSTR, mem_word(14'h3FFF));
        @(negedge CLK);
        chk("t6_dpc1", DEC_PC, 32'h0001_0000);
        chk("t6_dinstr1", DEC_INSTR, mem_word(14'h0000));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
